// File: rtl/demux_iact_burst_pkg.sv
// ============================================================================
//  Module   : iact_pkg
//  Brief    : Shared types, defaults and helpers for the iact burst demux.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package iact_pkg;

  // Burst FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned c_def_width   = 20;
  localparam int unsigned c_def_i_count = 3;
  localparam int unsigned c_def_len_w   = 8;

  // Select field must also encode the extra "discard" index I_COUNT.
  function automatic int unsigned sel_width(input int unsigned i_count);
    return $clog2(i_count + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_iact_burst_if.sv
// ============================================================================
//  Module   : demux_iact_burst_if
//  Brief    : Control, input stream and per-path output bus of the demux.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux_iact_burst_if
  import iact_pkg::*;
#(
  parameter int WIDTH   = c_def_width,
  parameter int I_COUNT = c_def_i_count,
  parameter int LEN_W   = c_def_len_w,
  parameter int SEL_W   = sel_width(I_COUNT)
);
  // burst control
  logic                     start_i;
  logic [SEL_W-1:0]         sel_i;
  logic [LEN_W-1:0]         len_i;
  logic                     busy_o;
  logic                     done_o;
  // input stream
  logic [WIDTH-1:0]         a_i;
  logic                     b_i;
  logic                     c_o;
  // output paths
  logic [WIDTH*I_COUNT-1:0] a_o;
  logic [I_COUNT-1:0]       b_o;
  logic [I_COUNT-1:0]       c_i;

  modport master (
    output start_i, sel_i, len_i, a_i, b_i, c_i,
    input  busy_o, done_o, c_o, a_o, b_o
  );

  modport slave (
    input  start_i, sel_i, len_i, a_i, b_i, c_i,
    output busy_o, done_o, c_o, a_o, b_o
  );

endinterface

`default_nettype wire

// File: rtl/demux_iact_burst_slice.sv
// ============================================================================
//  Module   : iact_reg_slice
//  Brief    : One-entry valid/ready register slice; reloads while being read.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iact_reg_slice #(
  parameter int WIDTH = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             r_full;
  logic [WIDTH-1:0] r_data;

  assign in_ready  = ~r_full | out_ready;
  assign out_valid = r_full;
  assign out_data  = r_data;

  // Capture on input transfer, otherwise empty on output transfer; data holds when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (in_valid && in_ready) begin
      r_full <= 1'b1;
      r_data <= in_data;
    end else if (out_ready) begin
      r_full <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_iact_burst.sv
// ============================================================================
//  Module   : demux_iact_burst
//  Brief    : Routes one iact stream to one of I_COUNT paths, one burst at a
//             time, through a registered slice per path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_iact_burst
  import iact_pkg::*;
#(
  parameter int WIDTH   = c_def_width,
  parameter int I_COUNT = c_def_i_count,
  parameter int LEN_W   = c_def_len_w
) (
  input logic               clk_i,
  input logic               rst_ni,
  demux_iact_burst_if.slave bus
);
  localparam int               SEL_W         = sel_width(I_COUNT);
  localparam logic [SEL_W-1:0] c_sel_discard = SEL_W'(I_COUNT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [I_COUNT-1:0] w_slice_valid;
  logic [I_COUNT-1:0] w_slice_ready;
  logic [I_COUNT-1:0] w_slice_full;
  logic               w_discard;
  logic               w_sel_ready;
  logic               w_drained;
  logic               w_in_xfer;
  logic               w_last;
  logic               w_c_o;
  logic               w_done;

  assign w_discard = (r_sel == c_sel_discard);
  assign w_in_xfer = bus.b_i & w_c_o;
  // Counter stops at len_q, so cnt+1 never exceeds the LEN_W range.
  assign w_last    = w_in_xfer & ((r_cnt + LEN_W'(1)) == r_len);
  // Every slice is empty, or is handing over its last word this cycle.
  assign w_drained = &(~w_slice_full | bus.c_i);

  // Ready of the selected slice; stays 0 for the discard index.
  always_comb begin
    w_sel_ready = 1'b0;
    for (int j = 0; j < I_COUNT; j++) begin
      if (r_sel == SEL_W'(j)) w_sel_ready = w_slice_ready[j];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start_i) w_state_nxt = (bus.len_i == '0) ? DRAIN : ROUTE;
      ROUTE:   if (w_last)      w_state_nxt = DRAIN;
      DRAIN:   if (w_drained)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: input ready, slice steering and completion pulse
  always_comb begin
    w_c_o         = 1'b0;
    w_done        = 1'b0;
    w_slice_valid = '0;
    case (r_state)
      ROUTE: begin
        w_c_o = w_discard | w_sel_ready;
        for (int j = 0; j < I_COUNT; j++) begin
          w_slice_valid[j] = bus.b_i & (r_sel == SEL_W'(j));
        end
      end
      DRAIN:   w_done = w_drained;
      default: ;
    endcase
  end

  assign bus.c_o    = w_c_o;
  assign bus.done_o = w_done;
  assign bus.busy_o = (r_state != IDLE);
  assign bus.b_o    = w_slice_full;

  // Burst context: destination and length latched at start, word counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sel <= '0;
      r_len <= '0;
      r_cnt <= '0;
    end else if ((r_state == IDLE) && bus.start_i) begin
      r_sel <= (bus.sel_i >= c_sel_discard) ? c_sel_discard : bus.sel_i;
      r_len <= bus.len_i;
      r_cnt <= '0;
    end else if ((r_state == ROUTE) && w_in_xfer) begin
      r_cnt <= r_cnt + LEN_W'(1);
    end
  end

  generate
    for (genvar j = 0; j < I_COUNT; j++) begin : g_slice
      iact_reg_slice #(.WIDTH(WIDTH)) u_slice (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (w_slice_valid[j]),
        .in_ready  (w_slice_ready[j]),
        .in_data   (bus.a_i),
        .out_valid (w_slice_full[j]),
        .out_ready (bus.c_i[j]),
        .out_data  (bus.a_o[WIDTH*j +: WIDTH])
      );
    end
  endgenerate

endmodule

`default_nettype wire
